ahb_spi_master: RTL and testbench

AHB-Lite slave peripheral giving the processor byte-wide SPI master access to the on-board accelerometer. It sits on the AHB-Lite bus beside the GPIO block and decodes a 16-byte register window. A write to TXDATA launches one 8-bit mode-0 transfer. A write to TXDATA while a transfer is in progress is held with wait states (HREADYOUT low) until the shifter is free.

---
 rtl/ahb_spi_master.sv | 185 ++++++++++++++++++
 tb/tb_ahb_spi_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_master.sv
// ahb_spi_master
//   AHB-Lite slave that gives the CPU a byte-wide, mode-0 SPI master for the
//   on-board accelerometer. 16-byte register window (HADDR[3:0]):
//     0x0 TXDATA  (W)  write [7:0] launches one 8-bit transfer, reads 0
//     0x4 RXDATA  (R)  last received byte, a read clears rx_valid
//     0x8 STATUS  (R)  bit0 busy, bit1 rx_valid, bit2 overrun (write 1 clears)
//     0xC CTRL    (RW) bit0 cs_en (spi_cs_n = ~cs_en), bit1 irq_en
//   Ports: AHB-Lite slave side (HCLK, HRESET, HSEL, HREADY, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA, HRDATA, HREADYOUT) and SPI side (spi_sclk,
//   spi_mosi, spi_miso, spi_cs_n).
//   Optional feature macro SPI_IRQ_EN: adds registered output spi_irq
//   (rx_valid & irq_en) and makes CTRL bit1 writable.
//   Parameter CLK_DIV: SCLK half-period in HCLK cycles (1..255).
module ahb_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
`ifdef SPI_IRQ_EN
  ,
  output logic        spi_irq
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        dp_active, dp_write, dp_wok;
  logic [1:0]  dp_sel;
  logic [7:0]  shift_reg, rx_data;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic        rx_valid, overrun, cs_en, irq_en;
  logic        busy, addr_ph, wr_en, tx_start, rd_rx, half_end, shift_end;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:4], HWDATA[31:8], HTRANS[0]};

  assign busy    = (state_reg != IDLE);
  assign addr_ph = HSEL & HTRANS[1] & HREADY;

  // Only a TXDATA write that would really launch a transfer is stalled;
  // it waits until the shifter is back in IDLE.
  assign HREADYOUT = ~(dp_active & dp_write & dp_wok & (dp_sel == 2'd0) & busy);

  assign wr_en     = dp_active & dp_write & dp_wok & HREADYOUT;
  assign tx_start  = wr_en & (dp_sel == 2'd0);
  assign rd_rx     = dp_active & ~dp_write & (dp_sel == 2'd1);
  assign half_end  = (div_cnt == DIV_LAST);
  assign shift_end = (state_reg == SHIFT) & half_end & spi_sclk & (bit_cnt == 3'd7);
  assign spi_cs_n  = ~cs_en;

  // Read data is captured at the address-phase edge so it is already valid
  // for the whole (zero-wait) data phase.
  always_comb begin
    rd_word = '0;
    unique case (HADDR[3:2])
      2'd1:    rd_word[7:0] = rx_data;
      2'd2:    rd_word[2:0] = {overrun, rx_valid, busy};
      2'd3:    rd_word[1:0] = {irq_en, cs_en};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (tx_start) state_next = SHIFT;
      SHIFT:   if (shift_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_wok    <= 1'b0;
      dp_sel    <= 2'd0;
      HRDATA    <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      cs_en     <= 1'b0;
    end else begin
      if (HREADY) begin
        dp_active <= addr_ph;
        dp_write  <= HWRITE;
        dp_sel    <= HADDR[3:2];
        // Writes only land at byte offset 0 with byte/half/word size.
        dp_wok    <= (HADDR[1:0] == 2'd0) && (HSIZE <= 3'd2);
        HRDATA    <= (addr_ph && !HWRITE) ? rd_word : '0;
      end

      unique case (state_reg)
        IDLE: begin
          if (tx_start) begin
            shift_reg <= HWDATA[7:0];
            spi_mosi  <= HWDATA[7];
            div_cnt   <= '0;
            bit_cnt   <= '0;
            spi_sclk  <= 1'b0;
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              // Rising edge: capture MISO into the LSB.
              spi_sclk  <= 1'b1;
              shift_reg <= {shift_reg[6:0], spi_miso};
            end else begin
              // Falling edge: the next TX bit is now at the MSB. After the
              // last bit MOSI simply holds.
              spi_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) spi_mosi <= shift_reg[7];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: ;
      endcase

      // A set from DONE beats a clear from an RXDATA read on the same edge,
      // and that coincident read is not an overrun.
      if (state_reg == DONE) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end

      if ((state_reg == DONE) && rx_valid && !rd_rx)
        overrun <= 1'b1;
      else if (wr_en && (dp_sel == 2'd2) && HWDATA[2])
        overrun <= 1'b0;

      if (wr_en && (dp_sel == 2'd3)) cs_en <= HWDATA[0];
    end
  end

`ifdef SPI_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_en  <= 1'b0;
      spi_irq <= 1'b0;
    end else begin
      if (wr_en && (dp_sel == 2'd3)) irq_en <= HWDATA[1];
      spi_irq <= rx_valid & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_spi_master.sv
// Testbench for ahb_spi_master: register vector table, hand-written timing
// sequences (loopback, busy boundary, back-to-back stall, overrun, same-edge
// read, reset mid-transfer) and a randomized register-level model check.
module tb_ahb_spi_master;
  localparam int CLK_DIV = 2;
  localparam int TX_CYC  = 16 * CLK_DIV + 1;
`ifdef SPI_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'h3;
`else
  localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

  logic        HCLK, HRESET, HSEL, HWRITE, spi_miso;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, spi_sclk, spi_mosi, spi_cs_n;
`ifdef SPI_IRQ_EN
  logic        spi_irq;
`endif

  ahb_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADYOUT),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
`ifdef SPI_IRQ_EN
    , .spi_irq(spi_irq)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // SPI slave stand-in: loopback, or present miso_pat MSB first, one bit
  // per SCLK rising edge.
  logic       loopback, sclk_q;
  logic [7:0] miso_pat;
  logic [2:0] rise_cnt, miso_idx;
  assign miso_idx = ~rise_cnt;
  assign spi_miso = loopback ? spi_mosi : miso_pat[miso_idx];
  always @(posedge HCLK) begin
    if (HRESET) rise_cnt <= 3'd0;
    else if (spi_sclk && !sclk_q) rise_cnt <= rise_cnt + 3'd1;
    sclk_q <= spi_sclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One complete AHB transfer: address phase, data phase (with wait states).
  task automatic ahb(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                     input logic [31:0] wdata, output logic [31:0] rdata, output int waits);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 300) begin
      @(negedge HCLK);
      waits++;
    end
    if (waits >= 300) chk("ahb_wait_bound", 32'(waits), 32'd0);
    rdata = HRDATA;
    $display("ahb %s addr=%h size=%0d wdata=%h rdata=%h waits=%0d",
             wr ? "WR" : "RD", addr, size, wdata, rdata, waits);
    @(posedge HCLK);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_cs_n;
  } vec_t;
  vec_t vecs[16];

  logic [31:0] rd, hi;
  int          w, rises, high, first_high, last_high;
  logic [7:0]  mosi_bits, pat, txb;
  logic        prev;
  logic [1:0]  sel, off;
  logic [2:0]  sz;
  int          kind;
  logic [7:0]  m_rx;
  logic        m_rxv, m_ovr, m_cs, m_irq;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = '0; loopback = 1'b0; miso_pat = 8'h00; sclk_q = 1'b0;

    vecs[0]  = '{"rd_status",   32'h8, 1'b0, 3'd2, 32'h0,        32'h0,     1'b1};
    vecs[1]  = '{"rd_ctrl",     32'hC, 1'b0, 3'd2, 32'h0,        32'h0,     1'b1};
    vecs[2]  = '{"rd_rxdata",   32'h4, 1'b0, 3'd2, 32'h0,        32'h0,     1'b1};
    vecs[3]  = '{"rd_txdata",   32'h0, 1'b0, 3'd2, 32'h0,        32'h0,     1'b1};
    vecs[4]  = '{"wb_ctrl",     32'hC, 1'b1, 3'd0, 32'h01,       32'h0,     1'b0};
    vecs[5]  = '{"rd_ctrl1",    32'hC, 1'b0, 3'd2, 32'h0,        32'h1,     1'b0};
    vecs[6]  = '{"wb_ctrl_p1",  32'hD, 1'b1, 3'd0, 32'h0,        32'h0,     1'b0};
    vecs[7]  = '{"rh_ctrl",     32'hC, 1'b0, 3'd1, 32'h0,        32'h1,     1'b0};
    vecs[8]  = '{"ww_ctrl3",    32'hC, 1'b1, 3'd2, 32'hFFFF_FF03, 32'h0,    1'b0};
    vecs[9]  = '{"rd_ctrl3",    32'hC, 1'b0, 3'd2, 32'h0,        CTRL_MASK, 1'b0};
    vecs[10] = '{"wr_rxdata",   32'h4, 1'b1, 3'd2, 32'h55,       32'h0,     1'b0};
    vecs[11] = '{"rd_rxdata2",  32'h4, 1'b0, 3'd2, 32'h0,        32'h0,     1'b0};
    vecs[12] = '{"wr_status",   32'h8, 1'b1, 3'd2, 32'hFF,       32'h0,     1'b0};
    vecs[13] = '{"rd_status2",  32'h8, 1'b0, 3'd2, 32'h0,        32'h0,     1'b0};
    vecs[14] = '{"ww_ctrl0",    32'hC, 1'b1, 3'd2, 32'h0,        32'h0,     1'b1};
    vecs[15] = '{"rd_ctrl0",    32'hFFFF_FFFC, 1'b0, 3'd2, 32'h0, 32'h0,    1'b1};

    // Reset held for two cycles.
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ahb(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, rd, w);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_cs_n"}, 32'(spi_cs_n), 32'(vecs[i].exp_cs_n));
    end

    // Loopback 0xA5: SCLK shape, MOSI bit order, received byte.
    loopback = 1'b1;
    ahb(32'hC, 1'b1, 3'd2, 32'h1, rd, w);
    chk("lb_cs_n", 32'(spi_cs_n), 32'd0);
    ahb(32'h0, 1'b1, 3'd2, 32'hA5, rd, w);
    rises = 0; high = 0; first_high = 0; last_high = 0; mosi_bits = 0; prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge HCLK);
      if (spi_sclk) begin
        high++;
        if (first_high == 0) first_high = k;
        last_high = k;
        if (!prev) begin
          rises++;
          mosi_bits = {mosi_bits[6:0], spi_mosi};
        end
      end
      prev = spi_sclk;
    end
    chk("lb_rises", 32'(rises), 32'd8);
    chk("lb_high_cycles", 32'(high), 32'(8 * CLK_DIV));
    chk("lb_first_high", 32'(first_high), 32'(CLK_DIV + 1));
    chk("lb_last_high", 32'(last_high), 32'(16 * CLK_DIV));
    chk("lb_mosi_bits", 32'(mosi_bits), 32'hA5);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("lb_status", rd, 32'h2);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("lb_rxdata", rd, 32'hA5);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("lb_status_clr", rd, 32'h0);

    // Busy window edges: status captured TX_CYC and TX_CYC+1 cycles after launch.
    ahb(32'h0, 1'b1, 3'd2, 32'h5A, rd, w);
    repeat (CLK_DIV * 4) @(posedge HCLK);
    ahb(32'h8, 1'b0, 3'd1, 0, rd, w); chk("half_status_busy", rd, 32'h1);
    repeat (TX_CYC + 2) @(posedge HCLK);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("busy_rx1", rd, 32'h5A);
    ahb(32'h0, 1'b1, 3'd2, 32'h5B, rd, w);
    repeat (TX_CYC - 1) @(posedge HCLK);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("status_last_busy", rd, 32'h1);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("busy_rx2", rd, 32'h5B);
    ahb(32'h0, 1'b1, 3'd2, 32'h5C, rd, w);
    repeat (TX_CYC) @(posedge HCLK);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("status_first_idle", rd, 32'h2);

    // RXDATA read completing on the DONE edge: old byte, rx_valid stays, no overrun.
    ahb(32'h0, 1'b1, 3'd2, 32'h81, rd, w);
    repeat (TX_CYC - 2) @(posedge HCLK);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("same_edge_old", rd, 32'h5C);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("same_edge_status", rd, 32'h2);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("same_edge_new", rd, 32'h81);

    // Back-to-back TXDATA writes: second data phase stalls while busy.
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK);
    @(negedge HCLK);
    HWDATA = 32'h3C;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hC3;
    w = 0;
    while (HREADYOUT !== 1'b1 && w < 300) begin
      @(negedge HCLK);
      w++;
    end
    $display("ahb WR pipelined addr=00000000 wdata=000000c3 waits=%0d", w);
    @(posedge HCLK);
    #1;
    chk("b2b_waits", 32'(w), 32'(TX_CYC));
    repeat (TX_CYC + 2) @(posedge HCLK);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("b2b_status", rd, 32'h6);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("b2b_rxdata", rd, 32'hC3);
    ahb(32'h8, 1'b1, 3'd2, 32'h4, rd, w);

    // Overrun with MISO held high.
    loopback = 1'b0; miso_pat = 8'hFF;
    for (int t = 0; t < 2; t++) begin
      ahb(32'h0, 1'b1, 3'd2, 32'h00, rd, w);
      repeat (TX_CYC + 2) @(posedge HCLK);
    end
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("ovr_status", rd, 32'h6);
    ahb(32'h8, 1'b1, 3'd2, 32'h4, rd, w);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("ovr_cleared", rd, 32'h2);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("ovr_rxdata", rd, 32'hFF);
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("ovr_status_end", rd, 32'h0);

    // Reset after three SCLK pulses.
    ahb(32'h0, 1'b1, 3'd2, 32'hFF, rd, w);
    for (int k = 0; k < 200 && rise_cnt != 3'd3; k++) @(negedge HCLK);
    chk("mid_rises", 32'(rise_cnt), 32'd3);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    chk("mid_sclk", 32'(spi_sclk), 32'd0);
    chk("mid_mosi", 32'(spi_mosi), 32'd0);
    chk("mid_cs_n", 32'(spi_cs_n), 32'd1);
    @(negedge HCLK);
    HRESET = 1'b0;
    ahb(32'h8, 1'b0, 3'd2, 0, rd, w); chk("mid_status", rd, 32'h0);
    ahb(32'h4, 1'b0, 3'd2, 0, rd, w); chk("mid_rxdata", rd, 32'h0);

    // Randomized register traffic against an abstract register model.
    m_rx = 8'h00; m_rxv = 1'b0; m_ovr = 1'b0; m_cs = 1'b0; m_irq = 1'b0;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      hi   = $urandom;
      off  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      sz   = 3'($urandom_range(0, 2));
      case (kind)
        0: begin
          pat = 8'($urandom); txb = 8'($urandom);
          miso_pat = pat;
          ahb({hi[31:4], 2'd0, off}, 1'b1, sz, {hi[31:8], txb}, rd, w);
          if (off == 2'd0) begin
            m_ovr = m_ovr | m_rxv; m_rxv = 1'b1; m_rx = pat;
            repeat (TX_CYC + 2) @(posedge HCLK);
          end
        end
        1: begin
          ahb({hi[31:4], 2'd1, off}, 1'b0, sz, 0, rd, w);
          chk("rnd_rxdata", rd, {24'h0, m_rx});
          m_rxv = 1'b0;
        end
        2: begin
          ahb({hi[31:4], 2'd2, off}, 1'b0, sz, 0, rd, w);
          chk("rnd_status", rd, {29'h0, m_ovr, m_rxv, 1'b0});
        end
        3: begin
          ahb({hi[31:4], 2'd2, off}, 1'b1, sz, $urandom, rd, w);
          if (off == 2'd0 && HWDATA[2]) m_ovr = 1'b0;
        end
        4: begin
          ahb({hi[31:4], 2'd3, off}, 1'b1, sz, $urandom, rd, w);
          if (off == 2'd0) begin
            m_cs = HWDATA[0];
            m_irq = HWDATA[1] & CTRL_MASK[1];
          end
        end
        default: begin
          ahb({hi[31:4], 2'd3, off}, 1'b0, sz, 0, rd, w);
          chk("rnd_ctrl", rd, {30'h0, m_irq, m_cs});
        end
      endcase
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rnd_cs_n", 32'(spi_cs_n), 32'(!m_cs));
`ifdef SPI_IRQ_EN
      chk("rnd_irq", 32'(spi_irq), 32'(m_rxv & m_irq));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
